// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared data-cache request encoding used by every client of the D-cache port.
//
// Contents:
//   cache_cmd_t : request command driven by a cache client
//                 NONE  - no request this cycle
//                 READ  - read the addressed 8-byte word
//                 WRITE - write the full 8-byte word
// -----------------------------------------------------------------------------
package cache_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } cache_cmd_t;

endpackage

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Types and helpers for the load/store execution stage.
//
// Contents:
//   lsu_size_t    : access size (B1/B2/B4/B8 = 1/2/4/8 bytes)
//   lsu_state_t   : stage FSM states (IDLE, RD, WR, DONE)
//   size_mask     : low-bit mask covering the bytes of an access
//   is_misaligned : access crosses the 8-byte word boundary
//   extract_load  : pull the addressed bytes out of a cache word and extend
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam int WORD_W = 64;

    typedef enum logic [1:0] {
        B1 = 2'd0,
        B2 = 2'd1,
        B4 = 2'd2,
        B8 = 2'd3
    } lsu_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    function automatic logic [WORD_W-1:0] size_mask(input lsu_size_t size);
        logic [WORD_W-1:0] mask;
        case (size)
            B1:      mask = 64'h0000_0000_0000_00FF;
            B2:      mask = 64'h0000_0000_0000_FFFF;
            B4:      mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return mask;
    endfunction

    // The sum is done in 4 bits so that offset 7 plus 8 bytes cannot wrap.
    function automatic logic is_misaligned(input logic [2:0] off, input lsu_size_t size);
        logic [3:0] nbytes;
        nbytes = 4'd1 << size;
        return (({1'b0, off} + nbytes) > 4'd8);
    endfunction

    function automatic logic [WORD_W-1:0] extract_load(input logic [WORD_W-1:0] word,
                                                       input logic [2:0]        off,
                                                       input lsu_size_t         size,
                                                       input logic              sgn);
        logic [WORD_W-1:0] value;
        value = (word >> {off, 3'b000}) & size_mask(size);
        if (sgn) begin
            case (size)
                B1:      value = {{56{value[7]}},  value[7:0]};
                B2:      value = {{48{value[15]}}, value[15:0]};
                B4:      value = {{32{value[31]}}, value[31:0]};
                default: value = value;
            endcase
        end
        return value;
    endfunction

endpackage

// File: rtl/lsu_store_merge.sv
// -----------------------------------------------------------------------------
// lsu_store_merge
// Combinational byte-lane merge for sub-word stores: the addressed bytes of
// the old cache word are replaced by the low bytes of the store data.
//
// Ports:
//   i_old  [63:0] : current contents of the cache word
//   i_data [63:0] : store data, only the low 'size' bytes are used
//   i_off  [2:0]  : byte offset of the store inside the word
//   i_size        : access size
//   o_word [63:0] : word to write back to the cache
// -----------------------------------------------------------------------------
module lsu_store_merge
    import lsu_pkg::*;
(
    input  logic [63:0] i_old,
    input  logic [63:0] i_data,
    input  logic [2:0]  i_off,
    input  lsu_size_t   i_size,
    output logic [63:0] o_word
);

    logic [5:0]  w_sh;
    logic [63:0] w_mask;

    assign w_sh   = {i_off, 3'b000};
    assign w_mask = size_mask(i_size);

    // A full-word store replaces everything, so the old word is ignored.
    assign o_word = (i_size == B8) ? i_data
                  : ((i_old & ~(w_mask << w_sh)) | ((i_data & w_mask) << w_sh));

endmodule

// File: rtl/lsu_pipe.sv
// -----------------------------------------------------------------------------
// lsu_pipe
// Single-issue load/store execution stage. Takes one memory micro-op from
// dispatch, talks to the data cache (read, or read-modify-write for sub-word
// stores), and returns a one-cycle completion pulse with tag and load value.
//
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   in_ready           : dispatch presents a micro-op this cycle
//   in_op              : 0 = load, 1 = store
//   in_size [1:0]      : 0/1/2/3 = 1/2/4/8 bytes
//   in_signed          : sign-extend the load result
//   in_addr            : effective address
//   in_data            : store data (low bytes)
//   in_tag             : destination id, passed through
//   busy               : stage occupied (RD/WR), dispatch must hold off
//   out_ready          : one-cycle completion pulse
//   out_tag, out_val   : completed tag, load result (0 for stores)
//   out_err            : misaligned access, no cache traffic issued
//   ca_req_cmd/addr/data : registered cache request
//   ca_respcyc, ca_resp_data : one-cycle cache completion and read data
// -----------------------------------------------------------------------------
module lsu_pipe
    import lsu_pkg::*, cache_pkg::*;
#(
    parameter int TAG_W  = 8,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_ready,
    input  logic              in_op,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              busy,
    output logic              out_ready,
    output logic [TAG_W-1:0]  out_tag,
    output logic [DATA_W-1:0] out_val,
    output logic              out_err,
    output cache_cmd_t        ca_req_cmd,
    output logic [ADDR_W-1:0] ca_req_addr,
    output logic [DATA_W-1:0] ca_req_data,
    input  logic              ca_respcyc,
    input  logic [DATA_W-1:0] ca_resp_data
);

    lsu_state_t        r_state;
    lsu_state_t        w_nextState;

    logic              r_isStore;
    lsu_size_t         r_size;
    logic              r_signed;
    logic [2:0]        r_off;
    logic [DATA_W-1:0] r_data;
    logic [TAG_W-1:0]  r_tag;

    logic              r_busy;
    logic              r_outReady;
    logic [TAG_W-1:0]  r_outTag;
    logic [DATA_W-1:0] r_outVal;
    logic              r_outErr;
    cache_cmd_t        r_cmd;
    logic [ADDR_W-1:0] r_reqAddr;
    logic [DATA_W-1:0] r_reqData;

    logic              w_accept;
    logic              w_latch;
    lsu_size_t         w_inSize;
    logic [ADDR_W-1:0] w_alignedAddr;
    logic [DATA_W-1:0] w_merged;
    logic              w_nextOutReady;
    logic [TAG_W-1:0]  w_nextOutTag;
    logic [DATA_W-1:0] w_nextOutVal;
    logic              w_nextOutErr;
    cache_cmd_t        w_nextCmd;
    logic [ADDR_W-1:0] w_nextReqAddr;
    logic [DATA_W-1:0] w_nextReqData;

    assign w_inSize      = lsu_size_t'(in_size);
    assign w_alignedAddr = {in_addr[ADDR_W-1:3], 3'b000};

    // DONE behaves like IDLE for dispatch so a new op can follow with no gap.
    assign w_accept = in_ready && ((r_state == IDLE) || (r_state == DONE));

    // The read response is merged in the same cycle it arrives, so the old
    // word never needs its own register.
    lsu_store_merge u_merge (
        .i_old  (ca_resp_data),
        .i_data (r_data),
        .i_off  (r_off),
        .i_size (r_size),
        .o_word (w_merged)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state plus the next value of every registered output.
    always_comb begin
        w_nextState    = r_state;
        w_latch        = 1'b0;
        w_nextOutReady = 1'b0;
        w_nextOutErr   = 1'b0;
        w_nextOutTag   = r_outTag;
        w_nextOutVal   = r_outVal;
        w_nextCmd      = r_cmd;
        w_nextReqAddr  = r_reqAddr;
        w_nextReqData  = r_reqData;

        case (r_state)
            IDLE, DONE: begin
                w_nextState = IDLE;
                w_nextCmd   = NONE;
                if (w_accept) begin
                    w_latch = 1'b1;
                    if (is_misaligned(in_addr[2:0], w_inSize)) begin
                        w_nextState    = DONE;
                        w_nextOutReady = 1'b1;
                        w_nextOutErr   = 1'b1;
                        w_nextOutTag   = in_tag;
                        w_nextOutVal   = '0;
                    end else if (in_op && (w_inSize == B8)) begin
                        w_nextState   = WR;
                        w_nextCmd     = WRITE;
                        w_nextReqAddr = w_alignedAddr;
                        w_nextReqData = in_data;
                    end else begin
                        w_nextState   = RD;
                        w_nextCmd     = READ;
                        w_nextReqAddr = w_alignedAddr;
                    end
                end
            end
            RD: begin
                if (ca_respcyc) begin
                    if (r_isStore) begin
                        w_nextState   = WR;
                        w_nextCmd     = WRITE;
                        w_nextReqData = w_merged;
                    end else begin
                        w_nextState    = DONE;
                        w_nextCmd      = NONE;
                        w_nextOutReady = 1'b1;
                        w_nextOutTag   = r_tag;
                        w_nextOutVal   = extract_load(ca_resp_data, r_off, r_size, r_signed);
                    end
                end
            end
            WR: begin
                if (ca_respcyc) begin
                    w_nextState    = DONE;
                    w_nextCmd      = NONE;
                    w_nextOutReady = 1'b1;
                    w_nextOutTag   = r_tag;
                    w_nextOutVal   = '0;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextCmd   = NONE;
            end
        endcase
    end

    // Op fields and registered outputs. busy only covers the cache phases so
    // that the DONE cycle is open to dispatch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_isStore  <= 1'b0;
            r_size     <= B1;
            r_signed   <= 1'b0;
            r_off      <= 3'd0;
            r_data     <= '0;
            r_tag      <= '0;
            r_busy     <= 1'b0;
            r_outReady <= 1'b0;
            r_outTag   <= '0;
            r_outVal   <= '0;
            r_outErr   <= 1'b0;
            r_cmd      <= NONE;
            r_reqAddr  <= '0;
            r_reqData  <= '0;
        end else begin
            if (w_latch) begin
                r_isStore <= in_op;
                r_size    <= w_inSize;
                r_signed  <= in_signed;
                r_off     <= in_addr[2:0];
                r_data    <= in_data;
                r_tag     <= in_tag;
            end
            r_busy     <= (w_nextState == RD) || (w_nextState == WR);
            r_outReady <= w_nextOutReady;
            r_outTag   <= w_nextOutTag;
            r_outVal   <= w_nextOutVal;
            r_outErr   <= w_nextOutErr;
            r_cmd      <= w_nextCmd;
            r_reqAddr  <= w_nextReqAddr;
            r_reqData  <= w_nextReqData;
        end
    end

    assign busy        = r_busy;
    assign out_ready   = r_outReady;
    assign out_tag     = r_outTag;
    assign out_val     = r_outVal;
    assign out_err     = r_outErr;
    assign ca_req_cmd  = r_cmd;
    assign ca_req_addr = r_reqAddr;
    assign ca_req_data = r_reqData;

endmodule

// File: tb/tb_lsu_pipe.sv
// -----------------------------------------------------------------------------
// tb_lsu_pipe
// Directed self-checking bench for lsu_pipe with a small cache responder.
// -----------------------------------------------------------------------------
module tb_lsu_pipe;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_ready;
    logic        in_op;
    logic [1:0]  in_size;
    logic        in_signed;
    logic [63:0] in_addr;
    logic [63:0] in_data;
    logic [7:0]  in_tag;
    logic        busy;
    logic        out_ready;
    logic [7:0]  out_tag;
    logic [63:0] out_val;
    logic        out_err;
    cache_cmd_t  ca_req_cmd;
    logic [63:0] ca_req_addr;
    logic [63:0] ca_req_data;
    logic        ca_respcyc;
    logic [63:0] ca_resp_data;

    int checks = 0;
    int passes = 0;

    // Cache responder controls and log
    logic        respAuto = 1'b1;
    int          respDelay = 1;
    logic [63:0] respReadData = '0;
    int          readCount = 0;
    int          writeCount = 0;
    logic [63:0] lastWriteData = '0;
    logic [63:0] lastWriteAddr = '0;
    int          outReadyCount = 0;
    int          cmdCycles = 0;

    lsu_pipe dut (
        .clk          (clk),
        .reset        (reset),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_size      (in_size),
        .in_signed    (in_signed),
        .in_addr      (in_addr),
        .in_data      (in_data),
        .in_tag       (in_tag),
        .busy         (busy),
        .out_ready    (out_ready),
        .out_tag      (out_tag),
        .out_val      (out_val),
        .out_err      (out_err),
        .ca_req_cmd   (ca_req_cmd),
        .ca_req_addr  (ca_req_addr),
        .ca_req_data  (ca_req_data),
        .ca_respcyc   (ca_respcyc),
        .ca_resp_data (ca_resp_data)
    );

    always #5 clk = ~clk;

    // Dispatch must never present an op while the stage reports busy.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(in_ready && busy))
                else $error("[TB] protocol: in_ready asserted while busy");
        end
    end

    // Cache model: a request seen in cycle C is answered in cycle C + respDelay.
    initial begin : responder
        bit inFlight;
        int waitCnt;
        inFlight = 0;
        waitCnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!respAuto) begin
                inFlight = 0;
            end else begin
                ca_respcyc = 1'b0;
                if (!inFlight && (ca_req_cmd != NONE)) begin
                    inFlight = 1;
                    waitCnt  = respDelay;
                end
                if (inFlight) begin
                    if (waitCnt == 0) begin
                        ca_respcyc = 1'b1;
                        inFlight   = 0;
                        if (ca_req_cmd == READ) begin
                            readCount++;
                            ca_resp_data = respReadData;
                        end else if (ca_req_cmd == WRITE) begin
                            writeCount++;
                            lastWriteData = ca_req_data;
                            lastWriteAddr = ca_req_addr;
                            ca_resp_data  = 64'h0;
                        end
                    end else begin
                        waitCnt--;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (out_ready) outReadyCount++;
        if (ca_req_cmd != NONE) cmdCycles++;
    end

    // Present one op for a single cycle (the accept cycle T); returns in T+1.
    task automatic applyStimulus(input logic op, input logic [1:0] size, input logic sgn,
                                 input logic [63:0] addr, input logic [63:0] data,
                                 input logic [7:0] tag);
        @(posedge clk);
        #1;
        in_op     = op;
        in_size   = size;
        in_signed = sgn;
        in_addr   = addr;
        in_data   = data;
        in_tag    = tag;
        in_ready  = 1'b1;
        @(posedge clk);
        #1;
        in_ready  = 1'b0;
    endtask

    // Wait (bounded) for out_ready; lat counts cycles after the accept cycle.
    // Returns at the negedge of the completion cycle, or lat = -1 on timeout.
    task automatic waitDone(input int offset, input int budget, output int lat);
        lat = -1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (out_ready) begin
                lat = n + offset;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passes++;
        checks++; if (out_ready !== 1'b0) $display("[TB] FAIL reset_out_ready: got %b expected 0", out_ready); else passes++;
        checks++; if (out_err !== 1'b0) $display("[TB] FAIL reset_out_err: got %b expected 0", out_err); else passes++;
        checks++; if (out_tag !== 8'h00) $display("[TB] FAIL reset_out_tag: got %h expected 00", out_tag); else passes++;
        checks++; if (out_val !== 64'h0) $display("[TB] FAIL reset_out_val: got %h expected 0", out_val); else passes++;
        checks++; if (ca_req_cmd !== NONE) $display("[TB] FAIL reset_cmd: got %0d expected 0", ca_req_cmd); else passes++;
        checks++; if (ca_req_addr !== 64'h0) $display("[TB] FAIL reset_addr: got %h expected 0", ca_req_addr); else passes++;
        checks++; if (ca_req_data !== 64'h0) $display("[TB] FAIL reset_data: got %h expected 0", ca_req_data); else passes++;
    endtask

    task automatic test_load8();
        int lat;
        respDelay    = 3;
        respReadData = 64'h1122_3344_5566_7788;
        applyStimulus(1'b0, 2'd3, 1'b0, 64'h1000, 64'h0, 8'h5A);
        @(negedge clk);
        checks++; if (busy !== 1'b1) $display("[TB] FAIL load8_busy_rise: got %b expected 1", busy); else passes++;
        checks++; if (ca_req_cmd !== READ) $display("[TB] FAIL load8_cmd: got %0d expected 1", ca_req_cmd); else passes++;
        checks++; if (ca_req_addr !== 64'h1000) $display("[TB] FAIL load8_addr: got %h expected 1000", ca_req_addr); else passes++;
        @(posedge clk);
        #1;
        waitDone(1, 20, lat);
        checks++; if (lat !== 5) $display("[TB] FAIL load8_latency: got %0d expected 5", lat); else passes++;
        checks++; if (out_val !== 64'h1122_3344_5566_7788) $display("[TB] FAIL load8_val: got %h expected 1122334455667788", out_val); else passes++;
        checks++; if (out_tag !== 8'h5A) $display("[TB] FAIL load8_tag: got %h expected 5a", out_tag); else passes++;
        checks++; if (out_err !== 1'b0) $display("[TB] FAIL load8_err: got %b expected 0", out_err); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL load8_busy_done: got %b expected 0", busy); else passes++;
        checks++; if (ca_req_cmd !== NONE) $display("[TB] FAIL load8_cmd_drop: got %0d expected 0", ca_req_cmd); else passes++;
        @(negedge clk);
        checks++; if (out_ready !== 1'b0) $display("[TB] FAIL load8_pulse_width: got %b expected 0", out_ready); else passes++;
    endtask

    task automatic test_load_extend();
        logic [63:0] addrs [3]  = '{64'h1003, 64'h1003, 64'h1006};
        logic [1:0]  sizes [3]  = '{2'd0, 2'd0, 2'd1};
        logic        sgns  [3]  = '{1'b1, 1'b0, 1'b1};
        logic [63:0] words [3]  = '{64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 64'h8001_0000_0000_0000};
        int          delays[3]  = '{1, 0, 2};
        logic [63:0] expVal[3]  = '{64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_0080, 64'hFFFF_FFFF_FFFF_8001};
        int          expLat[3]  = '{3, 2, 4};
        int lat;
        for (int i = 0; i < 3; i++) begin
            respDelay    = delays[i];
            respReadData = words[i];
            applyStimulus(1'b0, sizes[i], sgns[i], addrs[i], 64'h0, 8'(8'h70 + i));
            waitDone(0, 20, lat);
            checks++; if (lat !== expLat[i]) $display("[TB] FAIL extend%0d_latency: got %0d expected %0d", i, lat, expLat[i]); else passes++;
            checks++; if (out_val !== expVal[i]) $display("[TB] FAIL extend%0d_val: got %h expected %h", i, out_val, expVal[i]); else passes++;
        end
    endtask

    task automatic test_store_subword();
        int lat;
        readCount    = 0;
        writeCount   = 0;
        respDelay    = 1;
        respReadData = 64'hAAAA_AAAA_AAAA_AAAA;
        applyStimulus(1'b1, 2'd1, 1'b0, 64'h2002, 64'h1234_5678_9ABC_BEEF, 8'h21);
        waitDone(0, 20, lat);
        checks++; if (lat !== 5) $display("[TB] FAIL store2_latency: got %0d expected 5", lat); else passes++;
        checks++; if (lastWriteData !== 64'hAAAA_AAAA_BEEF_AAAA) $display("[TB] FAIL store2_wdata: got %h expected aaaaaaaabeefaaaa", lastWriteData); else passes++;
        checks++; if (lastWriteAddr !== 64'h2000) $display("[TB] FAIL store2_waddr: got %h expected 2000", lastWriteAddr); else passes++;
        checks++; if (readCount !== 1) $display("[TB] FAIL store2_reads: got %0d expected 1", readCount); else passes++;
        checks++; if (writeCount !== 1) $display("[TB] FAIL store2_writes: got %0d expected 1", writeCount); else passes++;
        checks++; if (out_val !== 64'h0) $display("[TB] FAIL store2_val: got %h expected 0", out_val); else passes++;
        checks++; if (out_tag !== 8'h21) $display("[TB] FAIL store2_tag: got %h expected 21", out_tag); else passes++;
    endtask

    task automatic test_store_full();
        int lat;
        readCount  = 0;
        writeCount = 0;
        respDelay  = 1;
        applyStimulus(1'b1, 2'd3, 1'b0, 64'h2808, 64'hDEAD_BEEF_CAFE_F00D, 8'h22);
        waitDone(0, 20, lat);
        checks++; if (lat !== 3) $display("[TB] FAIL store8_latency: got %0d expected 3", lat); else passes++;
        checks++; if (lastWriteData !== 64'hDEAD_BEEF_CAFE_F00D) $display("[TB] FAIL store8_wdata: got %h expected deadbeefcafef00d", lastWriteData); else passes++;
        checks++; if (readCount !== 0) $display("[TB] FAIL store8_reads: got %0d expected 0", readCount); else passes++;
        checks++; if (writeCount !== 1) $display("[TB] FAIL store8_writes: got %0d expected 1", writeCount); else passes++;
    endtask

    task automatic test_misaligned();
        int lat;
        int baseCmd;
        baseCmd = cmdCycles;
        applyStimulus(1'b0, 2'd2, 1'b0, 64'h3006, 64'h0, 8'h66);
        waitDone(0, 20, lat);
        checks++; if (lat !== 1) $display("[TB] FAIL misaligned_latency: got %0d expected 1", lat); else passes++;
        checks++; if (out_err !== 1'b1) $display("[TB] FAIL misaligned_err: got %b expected 1", out_err); else passes++;
        checks++; if (out_tag !== 8'h66) $display("[TB] FAIL misaligned_tag: got %h expected 66", out_tag); else passes++;
        repeat (3) @(negedge clk);
        checks++; if (cmdCycles !== baseCmd) $display("[TB] FAIL misaligned_no_cmd: got %0d expected %0d", cmdCycles, baseCmd); else passes++;
        checks++; if (out_err !== 1'b0) $display("[TB] FAIL misaligned_err_clear: got %b expected 0", out_err); else passes++;
    endtask

    task automatic test_back_to_back();
        int lat;
        respDelay    = 1;
        respReadData = 64'h0A0B_0C0D_0E0F_1011;
        applyStimulus(1'b0, 2'd3, 1'b0, 64'h4000, 64'h0, 8'h11);
        waitDone(0, 20, lat);
        checks++; if (lat !== 3) $display("[TB] FAIL b2b_first_latency: got %0d expected 3", lat); else passes++;
        checks++; if (out_tag !== 8'h11) $display("[TB] FAIL b2b_first_tag: got %h expected 11", out_tag); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL b2b_busy_in_done: got %b expected 0", busy); else passes++;
        // Second op presented during the DONE cycle of the first.
        respReadData = 64'h1111_2222_3333_4444;
        in_op     = 1'b0;
        in_size   = 2'd2;
        in_signed = 1'b0;
        in_addr   = 64'h4014;
        in_data   = 64'h0;
        in_tag    = 8'h22;
        in_ready  = 1'b1;
        @(posedge clk);
        #1;
        in_ready  = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) $display("[TB] FAIL b2b_second_busy: got %b expected 1", busy); else passes++;
        checks++; if (ca_req_addr !== 64'h4010) $display("[TB] FAIL b2b_second_addr: got %h expected 4010", ca_req_addr); else passes++;
        @(posedge clk);
        #1;
        waitDone(1, 20, lat);
        checks++; if (lat !== 3) $display("[TB] FAIL b2b_second_latency: got %0d expected 3", lat); else passes++;
        checks++; if (out_tag !== 8'h22) $display("[TB] FAIL b2b_second_tag: got %h expected 22", out_tag); else passes++;
        checks++; if (out_val !== 64'h0000_0000_1111_2222) $display("[TB] FAIL b2b_second_val: got %h expected 11112222", out_val); else passes++;
    endtask

    task automatic test_reset_midop();
        int lat;
        int baseReady;
        @(negedge clk);
        respAuto = 1'b0;
        applyStimulus(1'b0, 2'd3, 1'b0, 64'h5000, 64'h0, 8'h33);
        @(negedge clk);
        checks++; if (ca_req_cmd !== READ) $display("[TB] FAIL midreset_cmd_before: got %0d expected 1", ca_req_cmd); else passes++;
        baseReady = outReadyCount;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        ca_respcyc   = 1'b1;
        ca_resp_data = 64'hBAD0_BAD0_BAD0_BAD0;
        @(posedge clk);
        #1;
        ca_respcyc = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (outReadyCount !== baseReady) $display("[TB] FAIL midreset_no_ready: got %0d expected %0d", outReadyCount, baseReady); else passes++;
        checks++; if (ca_req_cmd !== NONE) $display("[TB] FAIL midreset_cmd: got %0d expected 0", ca_req_cmd); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %b expected 0", busy); else passes++;
        respAuto     = 1'b1;
        respDelay    = 2;
        respReadData = 64'h0102_0304_0506_0708;
        applyStimulus(1'b0, 2'd3, 1'b0, 64'h5008, 64'h0, 8'h44);
        waitDone(0, 20, lat);
        checks++; if (lat !== 4) $display("[TB] FAIL midreset_next_latency: got %0d expected 4", lat); else passes++;
        checks++; if (out_val !== 64'h0102_0304_0506_0708) $display("[TB] FAIL midreset_next_val: got %h expected 0102030405060708", out_val); else passes++;
        checks++; if (out_tag !== 8'h44) $display("[TB] FAIL midreset_next_tag: got %h expected 44", out_tag); else passes++;
    endtask

    initial begin
        reset        = 1'b1;
        in_ready     = 1'b0;
        in_op        = 1'b0;
        in_size      = 2'd0;
        in_signed    = 1'b0;
        in_addr      = '0;
        in_data      = '0;
        in_tag       = '0;
        ca_respcyc   = 1'b0;
        ca_resp_data = '0;

        test_reset();
        test_load8();
        test_load_extend();
        test_store_subword();
        test_store_full();
        test_misaligned();
        test_back_to_back();
        test_reset_midop();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
